// File: rtl/fc_requant_if.sv
// Frame-in / beat-out bundle for the FC requantizing serializer.
// slave is the serializer's view, master is the producer/consumer side.
interface fc_requant_if #(
    parameter int WIDTH   = 8,
    parameter int IN      = 128,
    parameter int NEURONS = 64
);
    localparam int IW   = 2 * WIDTH + $clog2(IN);
    localparam int IDXW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    logic [NEURONS*IW-1:0] z_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [IDXW-1:0]       out_idx;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport slave (
        input  z_in, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_valid, out_last
    );

    modport master (
        output z_in, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_valid, out_last
    );
endinterface

// File: rtl/fc_requant_serializer.sv
// Captures a frame of NEURONS wide neuron outputs, streams them as rounded/saturated WIDTH-bit beats.
// Latency: first beat valid 1 cycle after capture; a frame takes at least NEURONS+1 cycles.
// Backpressure: beats hold while out_ready=0; in_ready only in IDLE. FC_ARGMAX_EN adds argmax outputs.
module fc_requant_serializer #(
    parameter int WIDTH   = 8,
    parameter int IN      = 128,
    parameter int NEURONS = 64,
    parameter int SHIFT   = 7
) (
    input  logic clk,
    input  logic rst,
    fc_requant_if.slave bus
`ifdef FC_ARGMAX_EN
    ,
    output logic argmax_valid,
    output logic [((NEURONS > 1) ? $clog2(NEURONS) : 1)-1:0] argmax_idx
`endif
);
    localparam int IW   = 2 * WIDTH + $clog2(IN);
    localparam int IDXW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NEURONS - 1);
    localparam logic [IW:0] MAXV = (IW+1)'((1 << (WIDTH - 1)) - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic [IW-1:0]   frame_buf [NEURONS];
    logic [IW-1:0]   cur;
    logic [IW:0]     r;
    logic [WIDTH-1:0] sat;
    logic            stream_vld;
    logic            take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state <= STREAM;
                    idx   <= '0;
                end
                STREAM: if (bus.out_ready) begin
                    if (idx == LAST) state <= IDLE;
                    else             idx   <= idx + IDXW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer is only ever read after a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            for (int k = 0; k < NEURONS; k++) begin
                frame_buf[k] <= bus.z_in[k*IW +: IW];
            end
        end
    end

    assign cur = frame_buf[idx];

    // One extra bit keeps the rounding add from wrapping at full-scale input.
    if (SHIFT > 0) begin : g_round
        localparam logic [IW:0] RND = (IW+1)'(1) << (SHIFT - 1);
        assign r = ({1'b0, cur} + RND) >> SHIFT;
    end else begin : g_pass
        assign r = {1'b0, cur};
    end

    assign sat        = (r > MAXV) ? MAXV[WIDTH-1:0] : r[WIDTH-1:0];
    assign stream_vld = (state == STREAM) && !rst;
    assign take       = stream_vld && bus.out_ready;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = stream_vld;
    assign bus.out_last  = stream_vld && (idx == LAST);
    assign bus.out_idx   = stream_vld ? idx : '0;
    assign bus.out_data  = stream_vld ? sat : '0;

`ifdef FC_ARGMAX_EN
    logic [IW-1:0]   max_q;
    logic [IDXW-1:0] best_q;
    logic            better;

    // Strict compare: an equal later value never displaces the earlier index.
    assign better = (idx == '0) || (cur > max_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            argmax_valid <= 1'b0;
            argmax_idx   <= '0;
            max_q        <= '0;
            best_q       <= '0;
        end else begin
            argmax_valid <= 1'b0;
            if (take) begin
                if (better) begin
                    max_q  <= cur;
                    best_q <= idx;
                end
                if (idx == LAST) begin
                    argmax_valid <= 1'b1;
                    argmax_idx   <= better ? idx : best_q;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_fc_requant_serializer.sv
// Directed bench for fc_requant_serializer at default parameters (WIDTH=8, IN=128, NEURONS=64, SHIFT=7).
module tb_fc_requant_serializer;
    localparam int WIDTH   = 8;
    localparam int IN      = 128;
    localparam int NEURONS = 64;
    localparam int IW      = 23;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fc_requant_if #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS)) bus ();

`ifdef FC_ARGMAX_EN
    logic       argmax_valid;
    logic [5:0] argmax_idx;
`endif

    fc_requant_serializer #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS), .SHIFT(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FC_ARGMAX_EN
        ,
        .argmax_valid (argmax_valid),
        .argmax_idx   (argmax_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic beat_chk(input int e, input int exp_data);
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        chk("out_idx",   64'(bus.out_idx),   64'(e));
        chk("out_data",  64'(bus.out_data),  64'(exp_data));
        chk("out_last",  64'(bus.out_last),  64'(e == NEURONS - 1));
    endtask

    task automatic set_elem(input int k, input logic [IW-1:0] v);
        bus.z_in[k*IW +: IW] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] bv [8];
    int            be [8];
    logic [15:0]   pat;
    int            e;
    int            pulses;

    initial begin
        bus.z_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_out_idx",   64'(bus.out_idx),   64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
`ifdef FC_ARGMAX_EN
        chk("rst_argmax_valid", 64'(argmax_valid), 64'd0);
        chk("rst_argmax_idx",   64'(argmax_idx),   64'd0);
`endif
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Ramp frame: element k = 128k gives out_data = k
        for (int k = 0; k < NEURONS; k++) set_elem(k, IW'(128 * k));
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("ramp_in_ready_streaming", 64'(bus.in_ready), 64'd0);
        for (int k = 0; k < NEURONS; k++) begin
            beat_chk(k, (k < 127) ? k : 127);
            tick();
        end
        chk("ramp_in_ready_end",  64'(bus.in_ready),  64'd1);
        chk("ramp_out_valid_end", 64'(bus.out_valid), 64'd0);

        // Rounding and saturation boundaries
        bv = '{23'd63, 23'd64, 23'd191, 23'h3FFFFF, 23'h7FFFFF, 23'd16191, 23'd16192, 23'd16320};
        be = '{0, 1, 1, 127, 127, 126, 127, 127};
        bus.z_in = '0;
        for (int k = 0; k < 8; k++) set_elem(k, bv[k]);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat_chk(k, be[k]);
            tick();
        end
        for (int k = 8; k < NEURONS; k++) tick();
        chk("bound_in_ready_end", 64'(bus.in_ready), 64'd1);

        // Stalls with in_valid held high and z_in changed mid-frame
        for (int k = 0; k < NEURONS; k++) set_elem(k, IW'(300 * k + 100));
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.z_in = '1;
        pat = 16'b1001_0110_0011_1010;
        e = 0;
        for (int c = 0; c < 400 && e < NEURONS; c++) begin
            bus.out_ready = pat[c % 16];
            #1;
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            beat_chk(e, ((300 * e + 164) >> 7) < 127 ? ((300 * e + 164) >> 7) : 127);
            tick();
            if (pat[c % 16]) e++;
        end
        bus.in_valid = 1'b0;
        chk("stall_beats_done",     64'(e),             64'(NEURONS));
        chk("stall_in_ready_end",   64'(bus.in_ready),  64'd1);
        chk("stall_out_valid_end",  64'(bus.out_valid), 64'd0);

        // Reset in the middle of a frame
        bus.out_ready = 1'b1;
        for (int k = 0; k < NEURONS; k++) set_elem(k, IW'(128 * k));
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("pre_rst_idx", 64'(bus.out_idx), 64'd10);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("rst_next_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_next_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_next_out_idx",   64'(bus.out_idx),   64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rel_out_valid", 64'(bus.out_valid), 64'd0);
        for (int k = 0; k < NEURONS; k++) set_elem(k, IW'(256 * k));
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < NEURONS; k++) begin
            beat_chk(k, 2 * k);
            tick();
        end
        chk("restart_in_ready_end", 64'(bus.in_ready), 64'd1);

`ifdef FC_ARGMAX_EN
        // Tied maxima at 5 and 40 resolve to the lower index
        for (int k = 0; k < NEURONS; k++) set_elem(k, IW'(k));
        set_elem(5, 23'h7FFFFF);
        set_elem(40, 23'h7FFFFF);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < NEURONS; k++) begin
            if (argmax_valid) pulses++;
            tick();
        end
        chk("argmax_no_early_pulse", 64'(pulses),       64'd0);
        chk("argmax_valid_pulse",    64'(argmax_valid), 64'd1);
        chk("argmax_idx",            64'(argmax_idx),   64'd5);
        tick();
        chk("argmax_valid_drop", 64'(argmax_valid), 64'd0);
        chk("argmax_idx_hold",   64'(argmax_idx),   64'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fc_requant_serializer.md
FC_REQUANT_SERIALIZER -- requirements
Module: fc_requant_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: activation width in bits.
REQ-002 SHALL have parameter IN, default 128: fan-in of the upstream neuron; sets input element width IW = 2*WIDTH + ceil(log2(IN)), which is 23 at defaults.
REQ-003 SHALL have parameter NEURONS, default 64: neuron outputs per frame.
REQ-004 SHALL have parameter SHIFT, default 7: requantization right-shift, range 0..IW-1.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port z_in, input, NEURONS*IW bits: post-ReLU neuron outputs, element k at bits [k*IW +: IW], unsigned.
REQ-008 SHALL have port in_valid, input, 1 bit: z_in holds a complete frame.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a frame this cycle.
REQ-010 SHALL have port out_data, output, WIDTH bits: requantized activation, signed two's complement.
REQ-011 SHALL have port out_idx, output, ceil(log2(NEURONS)) bits: index of out_data.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data, out_idx and out_last are valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream consumer accepts.
REQ-014 SHALL have port out_last, output, 1 bit: high on the beat with out_idx = NEURONS-1.

Function
REQ-015 SHALL implement states IDLE and STREAM; in_ready SHALL equal (state == IDLE).
REQ-016 In IDLE, in_valid=1 SHALL capture all of z_in into an internal buffer, set the index to 0, and enter STREAM on the next cycle.
REQ-017 In STREAM, out_valid SHALL be 1, and in_valid SHALL be ignored.
REQ-018 First-beat latency SHALL be 1 cycle: out_valid rises in the cycle after the capture handshake.
REQ-019 A beat is accepted when out_valid & out_ready; on acceptance the index SHALL increment by 1.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-021 On acceptance of the beat with out_last=1, the block SHALL return to IDLE; in_ready SHALL be 1 in the following cycle, so a frame occupies at least NEURONS+1 cycles.
REQ-022 Requantization SHALL be r = (buf[idx] + 2^(SHIFT-1)) >> SHIFT when SHIFT>0, and r = buf[idx] when SHIFT=0, computed at IW+1 bits with no overflow.
REQ-023 out_data SHALL equal min(r, 2^(WIDTH-1)-1), so the output is always non-negative.
REQ-024 out_data SHALL be a function of registered state only (buffer and index), with no combinational path from z_in.

Reset
REQ-025 When rst=1 at a clock edge, the state SHALL go to IDLE and the index to 0.
REQ-026 While rst=1, out_valid, out_last, out_idx and out_data SHALL be 0 and in_ready SHALL be 0; in_ready SHALL be 1 in the first cycle after rst is released.
REQ-027 A reset during STREAM SHALL discard the frame; no further beats of that frame SHALL be emitted.
REQ-028 Buffer contents SHALL NOT need reset.

Configuration
REQ-029 Macro FC_ARGMAX_EN, when defined, SHALL add outputs argmax_valid (1 bit) and argmax_idx (ceil(log2(NEURONS)) bits).
- Tracking SHALL compare raw buffer values (pre-requant) on each accepted beat, using strict greater-than, so ties resolve to the lowest index.
- argmax_valid SHALL pulse for 1 cycle, in the cycle after the out_last beat is accepted.
- argmax_idx SHALL hold its value until the next frame's pulse; both outputs SHALL reset to 0.
REQ-030 With FC_ARGMAX_EN undefined, these ports and all tracking logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults unless stated)
REQ-031 Element k = 128*k, out_ready=1 -> 64 consecutive beats with out_data = min(k,127), out_idx = k, out_last only at idx 63, in_ready=1 on the cycle after the last beat.
REQ-032 Elements 63, 64, 191 with SHIFT=7 -> out_data 0, 1 (round half up), 1.
REQ-033 Element 2^22 - 1 -> out_data = 127 (saturation).
REQ-034 Toggle out_ready 1,0,0,1 pseudo-randomly -> no beat lost or duplicated, outputs held stable during stalls, in_valid ignored while streaming.
REQ-035 Assert rst at beat 10 -> out_valid=0 next cycle, in_ready=1 after release; a new frame restarts at out_idx 0.
REQ-036 FC_ARGMAX_EN defined, elements 5 and 40 both maximal -> one argmax_valid pulse with argmax_idx = 5.
